// File: rtl/ser_cml_multilane_if.sv
// rtl/ser_cml_multilane_if.sv - lane data/config and tap-output bundle for ser_cml_multilane
//
// Signals (serializer view, slave modport):
//   SER_EN_LANE   in   NUM_LANES             per-lane enable
//   SER_SEL_OUT   in   2*NUM_LANES           per-lane source select, lane k = [2k+1:2k]
//   SER_EN_TAP    in   2                     post-1 / post-2 tap enables
//   SER_INV_TAP   in   2                     post-1 / post-2 tap inverts
//   SER_WORD      in   NUM_LANES*WORD_WIDTH  parallel words, lane k = [k*WORD_WIDTH +: WORD_WIDTH]
//   SER_WORD_LOAD out  1                     word load strobe
//   SER_WORD_CLK  out  1                     divided word clock
//   TAP1/2/3      out  NUM_LANES             main / post-1 / post-2 taps
// The master modport is the word source / configuration side.
interface ser_cml_multilane_if #(
  parameter int NUM_LANES  = 4,
  parameter int WORD_WIDTH = 20
);
  logic [NUM_LANES-1:0]            SER_EN_LANE;
  logic [2*NUM_LANES-1:0]          SER_SEL_OUT;
  logic [1:0]                      SER_EN_TAP;
  logic [1:0]                      SER_INV_TAP;
  logic [NUM_LANES*WORD_WIDTH-1:0] SER_WORD;
  logic                            SER_WORD_LOAD;
  logic                            SER_WORD_CLK;
  logic [NUM_LANES-1:0]            TAP1;
  logic [NUM_LANES-1:0]            TAP2;
  logic [NUM_LANES-1:0]            TAP3;

  modport master (
    output SER_EN_LANE, SER_SEL_OUT, SER_EN_TAP, SER_INV_TAP, SER_WORD,
    input  SER_WORD_LOAD, SER_WORD_CLK, TAP1, TAP2, TAP3
  );

  modport slave (
    input  SER_EN_LANE, SER_SEL_OUT, SER_EN_TAP, SER_INV_TAP, SER_WORD,
    output SER_WORD_LOAD, SER_WORD_CLK, TAP1, TAP2, TAP3
  );
endinterface

// File: rtl/ser_cml_multilane.sv
// rtl/ser_cml_multilane.sv - multilane PISO serializer with source select and 3-tap FFE outputs
//
// Ports:
//   SER_TX_CLK  in  serial bit clock, all logic on its rising edge
//   SER_RST     in  synchronous active-high reset
//   bus         ser_cml_multilane_if.slave (lane enables, selects, tap config,
//               parallel words in; word load strobe, word clock, TAP1/2/3 out)
// Optional feature: define SER_PRBS_EN to build a per-lane PRBS7 source for
// select 2'b10; without it select 2'b10 carries the serial data.
module ser_cml_multilane #(
  parameter int NUM_LANES  = 4,
  parameter int WORD_WIDTH = 20,
  parameter int CNT_W      = 5
) (
  input  logic SER_TX_CLK,
  input  logic SER_RST,
  ser_cml_multilane_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(WORD_WIDTH / 2);

  logic [CNT_W-1:0]      cnt;
  logic [CNT_W-1:0]      cnt_nxt;
  logic                  load;
  logic                  word_clk_q;

  logic [WORD_WIDTH-1:0] shreg [NUM_LANES];
  logic [NUM_LANES-1:0]  clk_pat;
  logic [NUM_LANES-1:0]  src;
  logic [NUM_LANES-1:0]  b0;
  logic [NUM_LANES-1:0]  b1;
  logic [NUM_LANES-1:0]  b2;

  // Shared word counter: every lane's word boundary is tied to it.
  assign load = (cnt == CNT_LAST);

  always_comb begin
    cnt_nxt = cnt + 1'b1;
    if (load) begin
      cnt_nxt = '0;
    end
  end

  always_ff @(posedge SER_TX_CLK) begin
    if (SER_RST) begin
      cnt        <= '0;
      word_clk_q <= 1'b0;
    end else begin
      cnt        <= cnt_nxt;
      // Registered from the next count so the clock is glitch-free and
      // rises half a word after the load edge.
      word_clk_q <= (cnt_nxt >= CNT_HALF);
    end
  end

  assign bus.SER_WORD_LOAD = load;
  assign bus.SER_WORD_CLK  = word_clk_q;

`ifdef SER_PRBS_EN
  // PRBS7, x^7 + x^6 + 1, MSB is the output bit.
  logic [6:0] prbs [NUM_LANES];

  always_ff @(posedge SER_TX_CLK) begin
    if (SER_RST) begin
      for (int k = 0; k < NUM_LANES; k++) begin
        prbs[k] <= 7'h7F;
      end
    end else begin
      for (int k = 0; k < NUM_LANES; k++) begin
        if (bus.SER_EN_LANE[k]) begin
          prbs[k] <= {prbs[k][5:0], prbs[k][6] ^ prbs[k][5]};
        end
      end
    end
  end
`endif

  // Per-lane source select.
  always_comb begin
    src = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      case (bus.SER_SEL_OUT[2*k +: 2])
        2'b00:   src[k] = shreg[k][0];
        2'b01:   src[k] = clk_pat[k];
`ifdef SER_PRBS_EN
        2'b10:   src[k] = prbs[k][6];
`else
        2'b10:   src[k] = shreg[k][0];
`endif
        default: src[k] = 1'b0;
      endcase
    end
  end

  always_ff @(posedge SER_TX_CLK) begin
    if (SER_RST) begin
      for (int k = 0; k < NUM_LANES; k++) begin
        shreg[k] <= '0;
      end
      clk_pat <= '0;
      b0      <= '0;
      b1      <= '0;
      b2      <= '0;
    end else begin
      for (int k = 0; k < NUM_LANES; k++) begin
        if (!bus.SER_EN_LANE[k]) begin
          shreg[k] <= '0;
        end else if (load) begin
          shreg[k] <= bus.SER_WORD[k*WORD_WIDTH +: WORD_WIDTH];
        end else begin
          // LSB first: shift right, zero-fill so a re-enabled lane stays quiet
          // until the next word boundary.
          shreg[k] <= {1'b0, shreg[k][WORD_WIDTH-1:1]};
        end
      end
      clk_pat <= ~clk_pat;
      b0      <= src & bus.SER_EN_LANE;
      b1      <= b0;
      b2      <= b1;
    end
  end

  // Tap gating is combinational: enable/invert are quasi-static config.
  assign bus.TAP1 = b0;
  assign bus.TAP2 = bus.SER_EN_TAP[0] ? (b1 ^ {NUM_LANES{bus.SER_INV_TAP[0]}}) : '0;
  assign bus.TAP3 = bus.SER_EN_TAP[1] ? (b2 ^ {NUM_LANES{bus.SER_INV_TAP[1]}}) : '0;

endmodule

// File: tb/tb_ser_cml_multilane.sv
// tb/tb_ser_cml_multilane.sv - directed self-checking bench for ser_cml_multilane
module tb_ser_cml_multilane;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  ser_cml_multilane_if #(.NUM_LANES(4), .WORD_WIDTH(20)) bus ();

  ser_cml_multilane #(.NUM_LANES(4), .WORD_WIDTH(20), .CNT_W(5)) dut (
    .SER_TX_CLK (clk),
    .SER_RST    (rst),
    .bus        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [19:0] w [4];
  logic [3:0]  e1;
  logic [3:0]  p1;
  logic [3:0]  p2;

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    bus.SER_EN_LANE = 4'hF;
    bus.SER_SEL_OUT = 8'h00;
    bus.SER_EN_TAP  = 2'b00;
    bus.SER_INV_TAP = 2'b00;
    bus.SER_WORD    = '0;

    for (int i = 0; i < 4; i++) step();
    chk("rst_tap1", bus.TAP1, 4'h0);
    chk("rst_tap2", bus.TAP2, 4'h0);
    chk("rst_tap3", bus.TAP3, 4'h0);
    chk("rst_load", bus.SER_WORD_LOAD, 1'b0);
    chk("rst_wclk", bus.SER_WORD_CLK, 1'b0);

    // Load timing; lane0 word = 1
    rst = 1'b0;
    bus.SER_WORD = {60'h0, 20'h00001};
    for (int k = 1; k <= 19; k++) begin
      step();
      chk("load_a", bus.SER_WORD_LOAD, k == 19);
      chk("wclk_a", bus.SER_WORD_CLK, k >= 10);
    end

    // Serial order, taps disabled; word change mid-word must be ignored
    for (int k = 20; k <= 39; k++) begin
      step();
      chk("ser_tap1", bus.TAP1, (k == 21) ? 4'h1 : 4'h0);
      chk("ser_tap2", bus.TAP2, 4'h0);
      chk("ser_tap3", bus.TAP3, 4'h0);
      chk("load_b", bus.SER_WORD_LOAD, k == 39);
      chk("wclk_b", bus.SER_WORD_CLK, (k % 20) >= 10);
      if (k == 25) bus.SER_WORD = {60'h0, 20'hFFFFF};
      if (k == 39) begin
        bus.SER_WORD    = {60'h0, 20'h00001};
        bus.SER_EN_TAP  = 2'b11;
        bus.SER_INV_TAP = 2'b10;
      end
    end

    // FFE taps: post-1 plain, post-2 inverted
    for (int k = 40; k <= 59; k++) begin
      step();
      chk("ffe_tap1", bus.TAP1, (k == 41) ? 4'h1 : 4'h0);
      chk("ffe_tap2", bus.TAP2, (k == 42) ? 4'h1 : 4'h0);
      chk("ffe_tap3", bus.TAP3, (k == 43) ? 4'hE : 4'hF);
      chk("load_c", bus.SER_WORD_LOAD, k == 59);
      chk("wclk_c", bus.SER_WORD_CLK, (k % 20) >= 10);
      if (k == 59) begin
        bus.SER_WORD    = {4{20'hFFFFF}};
        bus.SER_INV_TAP = 2'b00;
      end
    end

    // Lane 2 disable mid-word, re-enable, other lanes untouched
    p1 = 4'h0;
    p2 = 4'h0;
    for (int k = 60; k <= 100; k++) begin
      step();
      e1 = {4{k >= 61}};
      e1[2] = (k >= 61 && k <= 65) || (k >= 81);
      chk("dis_tap1", bus.TAP1, e1);
      chk("dis_tap2", bus.TAP2, p1);
      chk("dis_tap3", bus.TAP3, p2);
      p2 = p1;
      p1 = e1;
      if (k == 65) bus.SER_EN_LANE = 4'b1011;
      if (k == 70) bus.SER_EN_LANE = 4'hF;
    end

    // Modes: lane1 clock pattern, lane3 idle, lanes 0/2 data
    bus.SER_SEL_OUT = 8'hC4;
    bus.SER_EN_TAP  = 2'b00;
    for (int k = 101; k <= 110; k++) begin
      step();
      e1 = {1'b0, 1'b1, ((k - 1) % 2) != 0, 1'b1};
      chk("mode_tap1", bus.TAP1, e1);
      chk("mode_tap2", bus.TAP2, 4'h0);
    end

    // Reset mid-word
    rst = 1'b1;
    bus.SER_EN_TAP = 2'b11;
    step();
    chk("mrst_tap1", bus.TAP1, 4'h0);
    chk("mrst_tap2", bus.TAP2, 4'h0);
    chk("mrst_tap3", bus.TAP3, 4'h0);
    chk("mrst_load", bus.SER_WORD_LOAD, 1'b0);
    chk("mrst_wclk", bus.SER_WORD_CLK, 1'b0);
    rst = 1'b0;
    w[0] = 20'h12345;
    w[1] = 20'hFEDCB;
    w[2] = 20'h0F0F0;
    w[3] = 20'hAAAAA;
    bus.SER_WORD = {w[3], w[2], w[1], w[0]};
    for (int j = 1; j <= 19; j++) begin
      step();
      chk("rel_load", bus.SER_WORD_LOAD, j == 19);
      e1 = {1'b0, 1'b0, ((j - 1) % 2) != 0, 1'b0};
      chk("rel_tap1", bus.TAP1, e1);
    end
    bus.SER_SEL_OUT = 8'hAA;

`ifdef SER_PRBS_EN
    begin
      logic seq [254];
      int   mism;
      int   run;
      int   maxrun;
      int   ones;
      for (int i = 0; i < 254; i++) begin
        step();
        seq[i] = bus.TAP1[0];
        chk("prbs_lanes", bus.TAP1, {4{seq[i]}});
      end
      mism = 0;
      ones = 0;
      for (int i = 0; i < 127; i++) begin
        if (seq[i] != seq[i + 127]) mism++;
        if (seq[i]) ones++;
      end
      run = 0;
      maxrun = 0;
      for (int i = 0; i < 254; i++) begin
        run = seq[i] ? 0 : run + 1;
        if (run > maxrun) maxrun = run;
      end
      chk("prbs_period", mism, 0);
      chk("prbs_ones", ones, 64);
      chk("prbs_zero_run", maxrun < 7, 1'b1);
    end
`else
    for (int j = 20; j <= 40; j++) begin
      step();
      e1 = 4'h0;
      if (j >= 21) begin
        for (int l = 0; l < 4; l++) e1[l] = w[l][j - 21];
      end
      chk("sel10_tap1", bus.TAP1, e1);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
